rr_encoder_4to2: RTL and testbench
==================================

# rr_encoder_4to2

Round-robin request arbiter and encoder for four requesters. It selects one active request and registers its 2-bit index with a valid flag. It holds the grant until the consumer acknowledges it, then rotates priority. It sits directly upstream of the 2-to-4 decoder: `grant_idx` drives the decoder's 2-bit `in`, and the decoder's one-hot `d` becomes the per-requester grant lines.

## Interface
- `LOCK_GRANT`, default 1: 1 = a grant is held until `ack`, even if its request drops; 0 = a grant is withdrawn when its request drops.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input 4: request vector; bit i = requester i; level-sensitive.
- `ack` input 1: consumer accepts the current grant; meaningful only while `grant_valid`=1.
- `grant_idx` output 2: index of the granted requester, registered; MSB-first binary, 0..3.
- `grant_valid` output 1: `grant_idx` is valid, registered.
- `busy` output 1: equals `grant_valid`; provided for status/debug.

## Operation
- Internal state:
  - `ptr[1:0]`: highest-priority index.
  - FSM with states IDLE and GRANT.
- Selection: scan indices `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4, wrapping 3->0). The first index with `req` bit high wins.
- IDLE:
  - If `req`!=0: load the winner into `grant_idx`, set `grant_valid`=1, go to GRANT.
  - Else: stay in IDLE with `grant_valid`=0; `grant_idx` holds its last value.
- GRANT, `ack`=1:
  - Completes the grant; `ptr` <= `grant_idx`+1 (mod 4).
  - Re-arbitrate in the same cycle, using the current `req` and the updated `ptr`.
  - If any request remains: stay in GRANT with the new winner, no bubble cycle.
  - Else: go to IDLE and drop `grant_valid`.
  - The just-served requester keeps its `req` bit but now has the lowest priority.
- GRANT, `ack`=0:
  - `grant_idx` and `grant_valid` hold stable.
  - With `LOCK_GRANT`=1, changes on `req` are ignored.
- `LOCK_GRANT`=0:
  - If `req[grant_idx]`=0 and `ack`=0: go to IDLE, `grant_valid`=0, `ptr` unchanged. No re-arbitration in that cycle.
  - If `ack`=1 in the same cycle, the `ack` takes precedence.
- `ack` while `grant_valid`=0 is ignored; no state change.
- Reset (`rst_n`=0, any time, including mid-grant):
  - `grant_idx`=2'b00, `grant_valid`=0, `busy`=0, `ptr`=0, FSM=IDLE, applied immediately.
  - A grant interrupted by reset is lost.
  - The first edge after release arbitrates normally.

## Timing
- Request to grant latency is 1 cycle: `req` seen at edge N gives `grant_valid`=1 after edge N.
- Ack to next grant:
  - `ack` sampled at edge M updates `grant_idx` after edge M.
  - Back-to-back grants give one grant per cycle when `ack` is held high.
- All outputs are registered; there is no combinational path from `req` or `ack` to any output.
- `grant_idx` stays constant for every cycle `grant_valid`=1 and `ack`=0. Downstream decoder output is therefore glitch-free per cycle.
- Throughput bound: a single continuous requester with others idle gets a grant every cycle while `ack`=1.

## Test plan
- Reset: assert `rst_n`=0 mid-grant, e.g. `grant_idx`=2 valid -> `grant_valid`=0 and `grant_idx`=00 immediately, before the next edge. After release with `req`=0000 -> remain idle.
- Single request: `req`=0100, `ack` low for 3 cycles -> `grant_idx`=2, `grant_valid`=1 one cycle after `req`, stable all 3 cycles. Then `ack`=1, `req`=0000 -> `grant_valid`=0 next cycle, `ptr`=3.
- Rotation and wrap: `req`=1111 held, `ack`=1 every cycle from reset -> `grant_idx` sequence 0,1,2,3,0,1 with `grant_valid` continuously 1.
- Fairness with a skip: `ptr`=0, `req`=1010, `ack`=1 continuous -> grants 1,3,1,3; requesters 0 and 2 are never granted.
- `LOCK_GRANT`=1 vs 0: grant on index 1, then `req` drops to 0000 with `ack`=0.
  - `LOCK_GRANT`=1 -> `grant_idx`=1 and `grant_valid`=1 held.
  - `LOCK_GRANT`=0 -> `grant_valid`=0 next cycle, `ptr` still 0.
- Stray `ack`: `ack`=1 with `grant_valid`=0 and `req`=0000 -> no change. Then `req`=0001 -> `grant_idx`=0, `ptr` unchanged until the grant is acked.

Source files
------------

// File: rtl/rr_encoder_4to2.sv
// Round-robin arbiter/encoder for four requesters: registers the winning 2-bit
// index with a valid flag, holds it until acked, then rotates priority.
module rr_encoder_4to2 #(
    parameter bit LOCK_GRANT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q;
    logic [1:0] ptr_q;
    logic [1:0] idx_q;
    logic       vld_q;

    logic [1:0] ptr_d;
    logic [2:0] sel_cur;
    logic [2:0] sel_ack;

    // Returns {found, index}: first set bit of r scanning p, p+1, p+2, p+3 mod 4.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] k;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            k = p + 2'(i);
            if (r[k]) begin
                res = {1'b1, k};
            end
        end
        return res;
    endfunction

    // On ack the pointer moves past the served requester before re-arbitrating.
    assign ptr_d   = idx_q + 2'd1;
    assign sel_cur = pick(req, ptr_q);
    assign sel_ack = pick(req, ptr_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_cur[2]) begin
                        idx_q   <= sel_cur[1:0];
                        vld_q   <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        ptr_q <= ptr_d;
                        if (sel_ack[2]) begin
                            idx_q <= sel_ack[1:0];
                        end else begin
                            vld_q   <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if (!LOCK_GRANT && !req[idx_q]) begin
                        vld_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    vld_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant_idx   = idx_q;
    assign grant_valid = vld_q;
    assign busy        = vld_q;

endmodule

// File: tb/tb_rr_encoder_4to2.sv
// Scoreboard bench: drives both LOCK_GRANT variants from the same stimulus and
// compares each cycle's registered outputs against hand-computed expectations.
module tb_rr_encoder_4to2;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic [1:0] idx1, idx0;
    logic       vld1, vld0, busy1, busy0;

    int n_cmp;
    int n_err;

    typedef struct packed {
        logic       v1;
        logic [1:0] i1;
        logic       v0;
        logic [1:0] i0;
    } exp_t;

    exp_t q[$];

    rr_encoder_4to2 #(.LOCK_GRANT(1'b1)) dut_lock (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
        .grant_idx(idx1), .grant_valid(vld1), .busy(busy1)
    );

    rr_encoder_4to2 #(.LOCK_GRANT(1'b0)) dut_nolock (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
        .grant_idx(idx0), .grant_valid(vld0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Inputs change on the falling edge; the expectation is for the next rising edge.
    task automatic step(input logic [3:0] r, input logic a,
                        input logic ev1, input logic [1:0] ei1,
                        input logic ev0, input logic [1:0] ei0);
        @(negedge clk);
        req = r;
        ack = a;
        q.push_back({ev1, ei1, ev0, ei0});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        ack   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one expectation per cycle, sampled just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("lock_valid",   {1'b0, vld1},  {1'b0, e.v1});
                chk("lock_idx",     idx1,          e.i1);
                chk("lock_busy",    {1'b0, busy1}, {1'b0, e.v1});
                chk("nolock_valid", {1'b0, vld0},  {1'b0, e.v0});
                chk("nolock_idx",   idx0,          e.i0);
                chk("nolock_busy",  {1'b0, busy0}, {1'b0, e.v0});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        ack   = 1'b0;
        #1;
        chk("reset_valid", {1'b0, vld1}, 2'd0);
        chk("reset_idx",   idx1,         2'd0);
        do_reset();

        // Rotation and wrap with every requester active and ack held high.
        step(4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0);
        step(4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1);
        step(4'b1111, 1'b1, 1'b1, 2'd2, 1'b1, 2'd2);
        step(4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 2'd3);
        step(4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0);
        step(4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1);
        step(4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 2'd1);

        // Single request held without ack, then released; pointer lands on 3.
        do_reset();
        step(4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2);
        step(4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2);
        step(4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2);
        step(4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 2'd2);
        step(4'b1111, 1'b0, 1'b1, 2'd3, 1'b1, 2'd3);
        step(4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0);
        step(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);

        // Fairness with gaps: only requesters 1 and 3 alternate.
        do_reset();
        step(4'b1010, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1);
        step(4'b1010, 1'b1, 1'b1, 2'd3, 1'b1, 2'd3);
        step(4'b1010, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1);
        step(4'b1010, 1'b1, 1'b1, 2'd3, 1'b1, 2'd3);
        step(4'b1010, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1);
        step(4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 2'd1);

        // Request drop without ack: locked variant holds, unlocked one withdraws.
        do_reset();
        step(4'b0010, 1'b0, 1'b1, 2'd1, 1'b1, 2'd1);
        step(4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 2'd1);
        step(4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 2'd1);
        step(4'b1111, 1'b0, 1'b1, 2'd1, 1'b1, 2'd0);
        step(4'b1111, 1'b1, 1'b1, 2'd2, 1'b1, 2'd1);
        step(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0, 2'd1);

        // Asynchronous reset in the middle of a cycle while index 2 is granted.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {1'b0, vld1},  2'd0);
        chk("async_rst_idx",   idx1,          2'd0);
        chk("async_rst_busy",  {1'b0, busy1}, 2'd0);
        chk("async_rst_nl_idx", idx0,         2'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0000;
        ack   = 1'b0;
        q.push_back({1'b0, 2'd0, 1'b0, 2'd0});

        // Stray ack while idle, then a grant that only moves the pointer once acked.
        step(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        step(4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0);
        step(4'b0011, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0);
        step(4'b0011, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1);
        step(4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0);
        step(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);

        @(negedge clk);
        req = 4'b0000;
        ack = 1'b0;
        @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
